// File: rtl/icache_repl_ctrl.sv
// Replacement sequencer for the icache LRU unit: picks a victim way per refill,
// holds it through the line fill, commits it, and shares the LRU update port with hit promotion.
module icache_repl_ctrl #(
  parameter  int P_NWAYS  = 4,
  parameter  int P_WDEPTH = 64,
  parameter  int P_CNTW   = 8,
  localparam int WAYW     = $clog2(P_NWAYS),
  localparam int SETW     = $clog2(P_WDEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               hit_valid_i,
  input  logic [SETW-1:0]    hit_set_i,
  input  logic [WAYW-1:0]    hit_way_i,
  input  logic [P_NWAYS-1:0] hit_vbits_i,
  input  logic               miss_req_i,
  input  logic [SETW-1:0]    miss_set_i,
  output logic               miss_gnt_o,
  input  logic [P_NWAYS-1:0] way_vbits_i,
  output logic               victim_valid_o,
  output logic [WAYW-1:0]    victim_way_o,
  input  logic               fill_done_i,
  output logic               busy_o,
  input  logic [WAYW-1:0]    lru_way_i,
  output logic [SETW-1:0]    lru_addr_o,
  output logic               lru_flush_o,
  output logic               lru_replace_o,
  output logic               lru_update_o,
  output logic [SETW-1:0]    lru_set_idx_o,
  output logic [WAYW-1:0]    lru_rep_way_o,
  output logic [WAYW-1:0]    lru_upd_way_o,
  output logic [P_NWAYS-1:0] lru_vbits_o,
  output logic [P_CNTW-1:0]  drop_cnt_o
);

  // state  | meaning
  // IDLE   | waiting for a refill request
  // LOOKUP | LRU unit addressed with the miss set, victim chosen
  // FILL   | victim held while the line is written
  // COMMIT | replacement pulsed to the LRU unit
  typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_FILL, ST_COMMIT} state_t;

  state_t state_q, state_d;

  logic [SETW-1:0]    miss_set_q;
  logic [WAYW-1:0]    victim_q, victim_d;
  logic [P_NWAYS-1:0] vbits_q;

  logic               hbuf_vld_q;
  logic [SETW-1:0]    hbuf_set_q;
  logic [WAYW-1:0]    hbuf_way_q;
  logic [P_NWAYS-1:0] hbuf_vbits_q;
  logic               hit_issue;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (miss_req_i) state_d = ST_LOOKUP;
        ST_LOOKUP: state_d = ST_FILL;
        ST_FILL:   if (fill_done_i) state_d = ST_COMMIT;
        ST_COMMIT: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    miss_gnt_o     = 1'b0;
    victim_valid_o = 1'b0;
    victim_way_o   = '0;
    lru_addr_o     = '0;
    lru_replace_o  = 1'b0;
    lru_update_o   = 1'b0;
    lru_set_idx_o  = '0;
    lru_rep_way_o  = '0;
    lru_upd_way_o  = '0;
    lru_vbits_o    = '0;
    lru_flush_o    = flush_i;
    busy_o         = (state_q != ST_IDLE);
    // COMMIT owns the update port, so the buffered hit waits a cycle there
    hit_issue      = hbuf_vld_q && (state_q != ST_COMMIT) && !flush_i;
    case (state_q)
      ST_IDLE:   miss_gnt_o = miss_req_i & ~flush_i;
      ST_LOOKUP: lru_addr_o = miss_set_q;
      ST_FILL: begin
        victim_valid_o = 1'b1;
        victim_way_o   = victim_q;
      end
      ST_COMMIT: begin
        if (!flush_i) begin
          lru_replace_o = 1'b1;
          lru_set_idx_o = miss_set_q;
          lru_rep_way_o = victim_q;
          lru_vbits_o   = vbits_q | (P_NWAYS'(1) << victim_q);
        end
      end
      default: ;
    endcase
    if (hit_issue) begin
      lru_update_o  = 1'b1;
      lru_set_idx_o = hbuf_set_q;
      lru_upd_way_o = hbuf_way_q;
      lru_vbits_o   = hbuf_vbits_q;
    end
  end

  // Lowest-indexed invalid way wins; a fully valid set falls back to LRU
  always_comb begin
    logic found;
    victim_d = lru_way_i;
    found    = 1'b0;
    for (int i = 0; i < P_NWAYS; i++) begin
      if (!found && !way_vbits_i[i]) begin
        victim_d = WAYW'(i);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      miss_set_q <= '0;
      victim_q   <= '0;
      vbits_q    <= '0;
    end else begin
      if (state_q == ST_IDLE && miss_req_i && !flush_i) miss_set_q <= miss_set_i;
      if (state_q == ST_LOOKUP && !flush_i) begin
        victim_q <= victim_d;
        vbits_q  <= way_vbits_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hbuf_vld_q   <= 1'b0;
      hbuf_set_q   <= '0;
      hbuf_way_q   <= '0;
      hbuf_vbits_q <= '0;
      drop_cnt_o   <= '0;
    end else if (flush_i) begin
      hbuf_vld_q <= 1'b0;
    end else if (hit_valid_i) begin
      hbuf_vld_q   <= 1'b1;
      hbuf_set_q   <= hit_set_i;
      hbuf_way_q   <= hit_way_i;
      hbuf_vbits_q <= hit_vbits_i;
      if (hbuf_vld_q && !hit_issue && (drop_cnt_o != '1)) drop_cnt_o <= drop_cnt_o + 1'b1;
    end else if (hit_issue) begin
      hbuf_vld_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_icache_repl_ctrl.sv
// Directed bench for icache_repl_ctrl with hand-computed expectations.
module tb_icache_repl_ctrl;
  localparam int P_NWAYS = 4, P_WDEPTH = 64, P_CNTW = 8;

  logic       clk_i = 1'b0, rst_i = 1'b1, flush_i;
  logic       hit_valid_i, miss_req_i, fill_done_i;
  logic [5:0] hit_set_i, miss_set_i;
  logic [1:0] hit_way_i, lru_way_i;
  logic [3:0] hit_vbits_i, way_vbits_i;
  logic       miss_gnt_o, victim_valid_o, busy_o;
  logic       lru_flush_o, lru_replace_o, lru_update_o;
  logic [1:0] victim_way_o, lru_rep_way_o, lru_upd_way_o;
  logic [5:0] lru_addr_o, lru_set_idx_o;
  logic [3:0] lru_vbits_o;
  logic [7:0] drop_cnt_o;

  int n_chk = 0, n_pass = 0;

  icache_repl_ctrl #(.P_NWAYS(P_NWAYS), .P_WDEPTH(P_WDEPTH), .P_CNTW(P_CNTW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .hit_valid_i(hit_valid_i), .hit_set_i(hit_set_i), .hit_way_i(hit_way_i),
    .hit_vbits_i(hit_vbits_i), .miss_req_i(miss_req_i), .miss_set_i(miss_set_i),
    .miss_gnt_o(miss_gnt_o), .way_vbits_i(way_vbits_i), .victim_valid_o(victim_valid_o),
    .victim_way_o(victim_way_o), .fill_done_i(fill_done_i), .busy_o(busy_o),
    .lru_way_i(lru_way_i), .lru_addr_o(lru_addr_o), .lru_flush_o(lru_flush_o),
    .lru_replace_o(lru_replace_o), .lru_update_o(lru_update_o),
    .lru_set_idx_o(lru_set_idx_o), .lru_rep_way_o(lru_rep_way_o),
    .lru_upd_way_o(lru_upd_way_o), .lru_vbits_o(lru_vbits_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic clr_inputs();
    flush_i = 0; hit_valid_i = 0; hit_set_i = 0; hit_way_i = 0; hit_vbits_i = 0;
    miss_req_i = 0; miss_set_i = 0; way_vbits_i = 0; fill_done_i = 0; lru_way_i = 0;
  endtask

  // advance to just after the next rising edge; inputs are set here, checks follow a #1 settle
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_hit(input logic [5:0] s, input logic [1:0] w, input logic [3:0] v);
    hit_valid_i = 1; hit_set_i = s; hit_way_i = w; hit_vbits_i = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_inputs();
    #12;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_gnt", 32'(miss_gnt_o), 0);
    chk("rst_vv", 32'(victim_valid_o), 0);
    chk("rst_drop", 32'(drop_cnt_o), 0);
    rst_i = 0;

    // miss set 5, vbits 1011 -> victim 2
    tick();
    miss_req_i = 1; miss_set_i = 5; #1;
    chk("m5_gnt", 32'(miss_gnt_o), 1);
    chk("m5_idle_busy", 32'(busy_o), 0);
    tick();
    clr_inputs(); way_vbits_i = 4'b1011; lru_way_i = 1; #1;
    chk("m5_lookup_addr", 32'(lru_addr_o), 5);
    chk("m5_lookup_busy", 32'(busy_o), 1);
    tick();
    clr_inputs(); #1;
    chk("m5_vv", 32'(victim_valid_o), 1);
    chk("m5_victim", 32'(victim_way_o), 2);
    chk("m5_addr_fill", 32'(lru_addr_o), 0);
    tick();
    tick();
    miss_req_i = 1; miss_set_i = 12; #1;
    chk("m5_gnt_in_fill", 32'(miss_gnt_o), 0);
    tick();
    clr_inputs();
    tick();
    fill_done_i = 1; #1;
    chk("m5_victim_c6", 32'(victim_way_o), 2);
    chk("m5_norep_c6", 32'(lru_replace_o), 0);
    tick();
    clr_inputs(); #1;
    chk("m5_rep", 32'(lru_replace_o), 1);
    chk("m5_rep_set", 32'(lru_set_idx_o), 5);
    chk("m5_rep_way", 32'(lru_rep_way_o), 2);
    chk("m5_rep_vbits", 32'(lru_vbits_o), 4'b1111);
    chk("m5_rep_noupd", 32'(lru_update_o), 0);
    tick();
    fill_done_i = 1; #1;
    chk("m5_idle_rep", 32'(lru_replace_o), 0);
    chk("m5_idle_ws", 32'(lru_set_idx_o), 0);
    tick();
    clr_inputs(); #1;
    chk("fd_ignored", 32'(busy_o), 0);

    // miss set 9, all valid, LRU way 3; a hit issues during the fill
    miss_req_i = 1; miss_set_i = 9; #1;
    chk("m9_gnt", 32'(miss_gnt_o), 1);
    tick();
    clr_inputs(); way_vbits_i = 4'b1111; lru_way_i = 3;
    set_hit(2, 1, 4'b0011); #1;
    chk("m9_addr", 32'(lru_addr_o), 9);
    tick();
    clr_inputs(); #1;
    chk("m9_victim", 32'(victim_way_o), 3);
    chk("h2_upd", 32'(lru_update_o), 1);
    chk("h2_set", 32'(lru_set_idx_o), 2);
    chk("h2_way", 32'(lru_upd_way_o), 1);
    chk("h2_vbits", 32'(lru_vbits_o), 4'b0011);
    tick();
    fill_done_i = 1; #1;
    chk("h2_once", 32'(lru_update_o), 0);
    tick();
    clr_inputs(); #1;
    chk("m9_rep", 32'(lru_replace_o), 1);
    chk("m9_rep_set", 32'(lru_set_idx_o), 9);
    chk("m9_rep_way", 32'(lru_rep_way_o), 3);
    chk("m9_rep_vbits", 32'(lru_vbits_o), 4'b1111);

    // hit in COMMIT-1 overwritten by hit in COMMIT
    tick();
    miss_req_i = 1; miss_set_i = 5;
    tick();
    clr_inputs(); way_vbits_i = 4'b0001;
    tick();
    clr_inputs(); fill_done_i = 1; set_hit(5, 1, 4'b0011); #1;
    chk("dr_victim", 32'(victim_way_o), 1);
    tick();
    clr_inputs(); set_hit(7, 0, 4'b0001); #1;
    chk("dr_rep", 32'(lru_replace_o), 1);
    chk("dr_noupd", 32'(lru_update_o), 0);
    chk("dr_rep_vbits", 32'(lru_vbits_o), 4'b0011);
    tick();
    clr_inputs(); #1;
    chk("dr_cnt", 32'(drop_cnt_o), 1);
    chk("dr_upd", 32'(lru_update_o), 1);
    chk("dr_upd_set", 32'(lru_set_idx_o), 7);
    chk("dr_upd_way", 32'(lru_upd_way_o), 0);
    chk("dr_upd_vbits", 32'(lru_vbits_o), 4'b0001);
    tick();
    chk("dr_no_old", 32'(lru_update_o), 0);

    // flush during FILL with a buffered hit
    miss_req_i = 1; miss_set_i = 3;
    tick();
    clr_inputs(); way_vbits_i = 4'b0000;
    tick();
    clr_inputs(); set_hit(6, 2, 4'b0100); #1;
    chk("fl_victim", 32'(victim_way_o), 0);
    tick();
    clr_inputs(); flush_i = 1; fill_done_i = 1; miss_req_i = 1; miss_set_i = 4; #1;
    chk("fl_flush", 32'(lru_flush_o), 1);
    chk("fl_noupd", 32'(lru_update_o), 0);
    chk("fl_nogrant", 32'(miss_gnt_o), 0);
    chk("fl_ws", 32'(lru_set_idx_o), 0);
    tick();
    flush_i = 0; fill_done_i = 0; #1;
    chk("fl_flush_off", 32'(lru_flush_o), 0);
    chk("fl_vv", 32'(victim_valid_o), 0);
    chk("fl_norep", 32'(lru_replace_o), 0);
    chk("fl_buf_clr", 32'(lru_update_o), 0);
    chk("fl_regrant", 32'(miss_gnt_o), 1);
    chk("fl_drop_kept", 32'(drop_cnt_o), 1);
    tick();
    clr_inputs(); way_vbits_i = 4'b0111; fill_done_i = 1; #1;
    chk("fl2_addr", 32'(lru_addr_o), 4);
    tick();
    clr_inputs(); #1;
    chk("fl2_victim", 32'(victim_way_o), 3);
    chk("fl2_norep", 32'(lru_replace_o), 0);
    fill_done_i = 1;
    tick();
    clr_inputs(); #1;
    chk("fl2_rep_set", 32'(lru_set_idx_o), 4);
    chk("fl2_rep_way", 32'(lru_rep_way_o), 3);
    tick();

    // saturation: one forced drop per commit
    for (int i = 0; i < 300; i++) begin
      miss_req_i = 1; miss_set_i = 1;
      tick();
      clr_inputs(); way_vbits_i = 4'b1111;
      tick();
      clr_inputs(); fill_done_i = 1; set_hit(10, 1, 4'b1111);
      tick();
      clr_inputs(); set_hit(11, 2, 4'b1111);
      tick();
      clr_inputs(); #1;
      if (i == 252) chk("sat_254", 32'(drop_cnt_o), 254);
      if (i == 253) chk("sat_255", 32'(drop_cnt_o), 255);
    end
    chk("sat_hold", 32'(drop_cnt_o), 255);

    // async reset in the middle of a fill with victim 2
    miss_req_i = 1; miss_set_i = 5;
    tick();
    clr_inputs(); way_vbits_i = 4'b1011;
    tick();
    clr_inputs(); #1;
    chk("rf_victim", 32'(victim_way_o), 2);
    rst_i = 1; #1;
    chk("rf_vv", 32'(victim_valid_o), 0);
    chk("rf_way", 32'(victim_way_o), 0);
    chk("rf_busy", 32'(busy_o), 0);
    chk("rf_drop", 32'(drop_cnt_o), 0);
    tick();
    rst_i = 0;
    tick();
    chk("rf_idle", 32'(busy_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/icache_repl_ctrl.md
Name: icache_repl_ctrl

Overview:
Replacement controller that sequences the icache LRU unit. It accepts refill requests from the miss handler and picks a victim way: the lowest-indexed invalid way, otherwise the LRU way reported by the LRU unit. It holds that victim until the line fill completes, then commits the replacement. It also arbitrates the LRU unit's single update port between hit-promotion traffic and replacement commits, and it fans out flush.

Parameters:
P_NWAYS, 4, ways per set (power of 2, >=2); WAYW = $clog2(P_NWAYS)
P_WDEPTH, 64, sets in cache (power of 2); SETW = $clog2(P_WDEPTH)
P_CNTW, 8, width of saturating drop counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
flush_i  in  1  cache flush request
hit_valid_i  in  1  lookup hit, promote way
hit_set_i  in  SETW  set of hit
hit_way_i  in  WAYW  way of hit
hit_vbits_i  in  P_NWAYS  valid bits of hit set
miss_req_i  in  1  refill request
miss_set_i  in  SETW  set to refill
miss_gnt_o  out  1  request accepted this cycle
way_vbits_i  in  P_NWAYS  valid bits of miss set, sampled in LOOKUP
victim_valid_o  out  1  victim_way_o valid, fill in progress
victim_way_o  out  WAYW  chosen victim way
fill_done_i  in  1  line fill written
busy_o  out  1  state != IDLE
lru_way_i  in  WAYW  LRU way of set on lru_addr_o (combinational)
lru_addr_o  out  SETW  read set index to LRU unit
lru_flush_o  out  1  flush to LRU unit
lru_replace_o  out  1  replace pulse
lru_update_o  out  1  update pulse
lru_set_idx_o  out  SETW  write set index
lru_rep_way_o  out  WAYW  replaced way
lru_upd_way_o  out  WAYW  updated way
lru_vbits_o  out  P_NWAYS  valid bits accompanying replace/update
drop_cnt_o  out  P_CNTW  count of dropped hit updates, saturating

Behaviour:
- Reset (async, rst_i=1): state=IDLE, hit buffer empty, all registers and outputs 0, drop_cnt_o=0.
- FSM states: IDLE, LOOKUP, FILL, COMMIT.
- IDLE: miss_gnt_o = miss_req_i & ~flush_i. On grant, capture miss_set_i and go to LOOKUP.
- LOOKUP (1 cycle): lru_addr_o = captured set. Victim = lowest i with way_vbits_i[i]=0; if all bits are 1, victim = lru_way_i. Register the victim and way_vbits_i, then go to FILL. lru_addr_o is 0 outside LOOKUP.
- FILL: victim_valid_o=1 and victim_way_o stable. On fill_done_i, go to COMMIT. No timeout.
- COMMIT (1 cycle): lru_replace_o=1, lru_set_idx_o=miss set, lru_rep_way_o=victim, lru_vbits_o = captured vbits | onehot(victim). Then go to IDLE, so the next grant comes one cycle later at the earliest.
- Miss-to-replace latency: 3 cycles plus fill wait. Grant at cycle 0, LOOKUP at 1, FILL from 2, COMMIT in the cycle after fill_done_i.
- Hit path: hit_valid_i is captured into a 1-entry buffer holding set, way and vbits.
  - The buffer issues in the next cycle whenever the state is not COMMIT and flush_i=0.
  - Issue drives lru_update_o=1, lru_set_idx_o, lru_upd_way_o and lru_vbits_o from the buffer.
  - Latency is 1 cycle.
- Buffer issuing and a new hit in the same cycle: the new hit refills the buffer, nothing is dropped.
- Buffer full, not issuing (COMMIT cycle), and a new hit arrives: the new hit overwrites the buffer and drop_cnt_o increments, saturating at 2^P_CNTW-1.
- lru_replace_o and lru_update_o are never high together; replace has priority.
- A hit to the set currently being refilled is legal and is issued normally.
- Flush (any state):
  - lru_flush_o = flush_i, combinational, same cycle.
  - lru_replace_o and lru_update_o are forced to 0 and miss_gnt_o to 0.
  - Next state is IDLE, the buffer is cleared, and victim_valid_o is 0 from the next cycle.
  - A fill in progress is abandoned and no replace is committed.
  - drop_cnt_o is not cleared.
- fill_done_i outside FILL and miss_req_i outside IDLE are ignored. The requester holds miss_req_i until granted.
- Write-side outputs (lru_set_idx_o, lru_rep_way_o, lru_upd_way_o, lru_vbits_o) are 0 when neither pulse is active.

Test Plan:
- Reset mid-FILL (victim=2): assert rst_i -> all outputs 0 immediately, state IDLE, drop_cnt_o=0.
- Miss set 5, way_vbits_i=4'b1011 -> victim_way_o=2 at cycle 2; fill_done_i at cycle 6 -> cycle 7 lru_replace_o=1, set 5, rep_way 2, vbits 4'b1111.
- Miss set 9, way_vbits_i=4'b1111, lru_way_i=3 -> victim 3; after fill, replace set 9, way 3.
- Hit set 5 way 1 arrives in COMMIT-1, another hit set 7 way 0 in COMMIT -> set 5 way 1 is overwritten and never issued; drop_cnt_o=1; update set 7 way 0 issues the cycle after COMMIT.
- flush_i during FILL -> lru_flush_o=1 same cycle, victim_valid_o=0 next cycle, no lru_replace_o ever for that miss; new miss granted the next cycle.
- 300 forced drops -> drop_cnt_o saturates at 255.
